motor_pwm_guard: RTL
====================

Name: motor_pwm_guard

Overview:
- Downstream consumer of the overcurrent comparator's latched flag `oc`.
- Generates the motor H-bridge PWM pair from a requested duty and direction.
- On `oc`, kills drive immediately, waits a cooldown, then retries.
- After too many consecutive trips it locks out until the reset button is pressed.

Parameters:
- PWM_BITS, 8, width of duty and of the PWM period counter (period = 2^PWM_BITS clocks).
- COOLDOWN_CYCLES, 1000, clocks spent with drive off after each trip (must be ≥ 2).
- MAX_RETRIES, 3, trips tolerated before lockout (must be ≥ 1).

Ports:
- clock  input  1  system clock, rising edge.
- resetBTN  input  1  asynchronous, active-high reset.
- oc  input  1  overcurrent flag from comparator, synchronous to clock.
- enable  input  1  drive request; level-sensitive.
- dir  input  1  0 = forward (pwm_a), 1 = reverse (pwm_b).
- duty  input  PWM_BITS  requested on-time in clocks per period.
- pwm_a  output  1  forward bridge drive.
- pwm_b  output  1  reverse bridge drive.
- fault_active  output  1  high in COOLDOWN or LOCKOUT.
- locked_out  output  1  high only in LOCKOUT.
- retry_count  output  $clog2(MAX_RETRIES+1)  trips since last IDLE.

Behaviour:
- Reset (async, any state): state = IDLE.
  - Period counter, cooldown counter, retry_count, duty/dir latches = 0.
  - pwm_a = pwm_b = fault_active = locked_out = 0.
- All outputs are registered. pwm_a and pwm_b are never high together under any condition.
- Period counter: free-running 0 .. 2^PWM_BITS−1, wraps to 0, runs in all states.
- duty and dir are latched only at counter value 0 (period start), so mid-period changes take effect at the next period.
- Drive rule in RUN: the selected output = (counter < duty_latched).
  - duty = 0 gives constant low.
  - duty = max gives high for 2^PWM_BITS−1 of 2^PWM_BITS clocks.
- Dead time: if the newly latched dir differs from the previous latched dir, both outputs stay low for that entire period.
- States:
  - IDLE:
    - Outputs low; retry_count cleared.
    - Transitions to RUN at the next period start with enable = 1 and oc = 0.
  - RUN:
    - PWM per the drive rule.
    - enable = 0 → IDLE at the next edge; outputs low from that edge.
  - COOLDOWN:
    - Outputs low; fault_active = 1.
    - The cooldown counter counts COOLDOWN_CYCLES clocks.
    - On expiry: if oc = 0 and enable = 1 → RUN; if oc = 0 and enable = 0 → IDLE.
    - On expiry with oc still 1: counts as a new trip (same retry/lockout rule as RUN), and the cooldown restarts.
  - LOCKOUT:
    - Outputs low; fault_active = locked_out = 1.
    - Exit only via resetBTN; enable and oc are ignored.
- Trip rule (RUN, or cooldown expiry with oc = 1):
  - If retry_count < MAX_RETRIES: retry_count increments and the state enters COOLDOWN.
  - Otherwise: the state enters LOCKOUT and retry_count holds at MAX_RETRIES.
- Trip latency: oc sampled 1 at edge N → pwm outputs low and fault_active high from edge N. This uses next-state decode, so there is no extra cycle of drive.
- Simultaneous events:
  - oc = 1 together with enable falling: trip wins.
  - oc = 1 in IDLE: ignored, no trip, but blocks entry to RUN.
- Reset mid-operation (including mid-cooldown): immediate return to reset values.
- Recovery from RUN to IDLE clears retry_count. Re-entry to RUN from COOLDOWN does not clear it.

Decomposition:
- Shared package holds:
  - the state enum (IDLE, RUN, COOLDOWN, LOCKOUT);
  - default constants PWM_BITS_DEF, COOLDOWN_DEF, MAX_RETRIES_DEF.
- One sub-module: pwm_period_gen.
  - Contents: period counter, duty/dir latch at wrap, dead-time detect.
  - Outputs: period_start, raw_pwm, dir_latched, dead.
- The guard FSM and the cooldown/retry counters stay in the top module.

Test Plan (bench parameters: PWM_BITS = 4, COOLDOWN_CYCLES = 20, MAX_RETRIES = 2):
1. enable = 1, dir = 0, duty = 5, oc = 0 → after the first period start, pwm_a is high 5 of every 16 clocks; pwm_b stays 0.
2. Running at duty 5, then oc pulses 1 for one clock at edge N → pwm_a low from edge N, fault_active = 1, retry_count = 1. After 20 clocks, RUN resumes at the next period's high phase.
3. oc held 1 continuously from RUN → retry_count steps 1 then 2 at 20-clock spacing. The next expiry gives locked_out = 1, and pwm stays 0 even after oc is released and enable toggles.
4. In LOCKOUT, pulse resetBTN asynchronously (between clock edges) → all outputs 0 and retry_count = 0 immediately. With enable = 1, RUN resumes at the next period start.
5. While running dir = 0 at duty 8, switch dir to 1 mid-period → pwm_a finishes the current period normally. The next full period has both outputs 0, and pwm_b then runs at 8 of 16.
6. oc = 1 and enable 1→0 on the same edge → state COOLDOWN, retry_count = 1. At expiry with oc = 0 and enable = 0 → IDLE, retry_count = 0.

Source files
------------

// File: rtl/motor_pwm_guard_pkg.sv
// Shared types, defaults and small helpers for the motor PWM guard.
package motor_pwm_guard_pkg;

  localparam int PWM_BITS_DEF    = 8;
  localparam int COOLDOWN_DEF    = 1000;
  localparam int MAX_RETRIES_DEF = 3;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_COOLDOWN = 2'd2,
    ST_LOCKOUT  = 2'd3
  } state_t;

  function automatic int retry_width(input int max_retries);
    return $clog2(max_retries + 1);
  endfunction

  function automatic logic is_fault(input state_t s);
    return (s == ST_COOLDOWN) || (s == ST_LOCKOUT);
  endfunction

endpackage

// File: rtl/motor_pwm_guard_if.sv
// Drive request and bridge/status bundle between the motor controller and the guard.
interface motor_pwm_guard_if
  import motor_pwm_guard_pkg::*;
#(
  parameter int PWM_BITS    = PWM_BITS_DEF,
  parameter int MAX_RETRIES = MAX_RETRIES_DEF
) ();

  localparam int RC_W = retry_width(MAX_RETRIES);

  logic                oc;
  logic                enable;
  logic                dir;
  logic [PWM_BITS-1:0] duty;
  logic                pwm_a;
  logic                pwm_b;
  logic                fault_active;
  logic                locked_out;
  logic [RC_W-1:0]     retry_count;

  modport master (
    output oc, enable, dir, duty,
    input  pwm_a, pwm_b, fault_active, locked_out, retry_count
  );

  modport slave (
    input  oc, enable, dir, duty,
    output pwm_a, pwm_b, fault_active, locked_out, retry_count
  );

endinterface

// File: rtl/motor_pwm_guard_period_gen.sv
// Free-running PWM period counter; duty/dir are sampled at count 0 and a
// direction change blanks the whole period that follows it.
module pwm_period_gen
  import motor_pwm_guard_pkg::*;
#(
  parameter int PWM_BITS = PWM_BITS_DEF
) (
  input  logic                clock,
  input  logic                resetBTN,
  input  logic [PWM_BITS-1:0] i_duty,
  input  logic                i_dir,
  output logic                o_period_start,
  output logic                o_raw_pwm,
  output logic                o_dir_latched,
  output logic                o_dead
);

  logic [PWM_BITS-1:0] r_cnt;
  logic [PWM_BITS-1:0] r_duty_l;
  logic                r_dir_l;
  logic                r_dead;

  logic                w_start;
  logic [PWM_BITS-1:0] w_duty_eff;
  logic                w_dir_eff;
  logic                w_dead_eff;

  // At count 0 the incoming request already governs this cycle, so the
  // effective values bypass the latches for that one count.
  assign w_start    = (r_cnt == '0);
  assign w_duty_eff = w_start ? i_duty : r_duty_l;
  assign w_dir_eff  = w_start ? i_dir : r_dir_l;
  assign w_dead_eff = w_start ? (i_dir != r_dir_l) : r_dead;

  always_ff @(posedge clock or posedge resetBTN) begin
    if (resetBTN) begin
      r_cnt    <= '0;
      r_duty_l <= '0;
      r_dir_l  <= 1'b0;
      r_dead   <= 1'b0;
    end else begin
      r_cnt <= r_cnt + PWM_BITS'(1);
      if (w_start) begin
        r_duty_l <= i_duty;
        r_dir_l  <= i_dir;
        r_dead   <= w_dead_eff;
      end
    end
  end

  assign o_period_start = w_start;
  assign o_raw_pwm      = (r_cnt < w_duty_eff);
  assign o_dir_latched  = w_dir_eff;
  assign o_dead         = w_dead_eff;

endmodule

// File: rtl/motor_pwm_guard.sv
// Overcurrent guard for the H-bridge PWM pair: trip, cool down, retry, lock out.
//   state    | meaning
//   IDLE     | drive off, retry count cleared, waits for enable at period start
//   RUN      | PWM on the selected leg
//   COOLDOWN | drive off for COOLDOWN_CYCLES after a trip
//   LOCKOUT  | drive off until resetBTN
module motor_pwm_guard
  import motor_pwm_guard_pkg::*;
#(
  parameter int PWM_BITS        = PWM_BITS_DEF,
  parameter int COOLDOWN_CYCLES = COOLDOWN_DEF,
  parameter int MAX_RETRIES     = MAX_RETRIES_DEF
) (
  input  logic               clock,
  input  logic               resetBTN,
  motor_pwm_guard_if.slave   bus
);

  localparam int RC_W = retry_width(MAX_RETRIES);
  localparam int CD_W = $clog2(COOLDOWN_CYCLES);
  localparam logic [RC_W-1:0] RC_MAX  = RC_W'(MAX_RETRIES);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

  logic w_period_start;
  logic w_raw_pwm;
  logic w_dir;
  logic w_dead;

  pwm_period_gen #(
    .PWM_BITS (PWM_BITS)
  ) u_period (
    .clock          (clock),
    .resetBTN       (resetBTN),
    .i_duty         (bus.duty),
    .i_dir          (bus.dir),
    .o_period_start (w_period_start),
    .o_raw_pwm      (w_raw_pwm),
    .o_dir_latched  (w_dir),
    .o_dead         (w_dead)
  );

  state_t          r_state;
  logic [RC_W-1:0] r_retry;
  logic [CD_W-1:0] r_cd;
  logic            r_pwm_a;
  logic            r_pwm_b;
  logic            r_fault;
  logic            r_lock;

  state_t          w_state_nxt;
  logic [RC_W-1:0] w_retry_nxt;
  logic [CD_W-1:0] w_cd_nxt;
  logic            w_trip;
  logic            w_drive;

  always_comb begin
    w_state_nxt = r_state;
    w_retry_nxt = r_retry;
    w_cd_nxt    = r_cd;
    w_trip      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_retry_nxt = '0;
        if (w_period_start && bus.enable && !bus.oc) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.oc) begin
          w_trip = 1'b1;
        end else if (!bus.enable) begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = '0;
        end
      end
      ST_COOLDOWN: begin
        if (r_cd != '0) begin
          w_cd_nxt = r_cd - CD_W'(1);
        end else if (bus.oc) begin
          w_trip = 1'b1;
        end else if (bus.enable) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
          w_retry_nxt = '0;
        end
      end
      default: begin
        w_state_nxt = ST_LOCKOUT;
      end
    endcase

    if (w_trip) begin
      if (r_retry < RC_MAX) begin
        w_retry_nxt = r_retry + RC_W'(1);
        w_state_nxt = ST_COOLDOWN;
        w_cd_nxt    = CD_LOAD;
      end else begin
        w_retry_nxt = RC_MAX;
        w_state_nxt = ST_LOCKOUT;
      end
    end
  end

  // Outputs decode from the next state so a trip removes drive on the same edge.
  assign w_drive = (w_state_nxt == ST_RUN) && w_raw_pwm && !w_dead;

  always_ff @(posedge clock or posedge resetBTN) begin
    if (resetBTN) begin
      r_state <= ST_IDLE;
      r_retry <= '0;
      r_cd    <= '0;
      r_pwm_a <= 1'b0;
      r_pwm_b <= 1'b0;
      r_fault <= 1'b0;
      r_lock  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_retry <= w_retry_nxt;
      r_cd    <= w_cd_nxt;
      r_pwm_a <= w_drive && !w_dir;
      r_pwm_b <= w_drive && w_dir;
      r_fault <= is_fault(w_state_nxt);
      r_lock  <= (w_state_nxt == ST_LOCKOUT);
    end
  end

  assign bus.pwm_a        = r_pwm_a;
  assign bus.pwm_b        = r_pwm_b;
  assign bus.fault_active = r_fault;
  assign bus.locked_out   = r_lock;
  assign bus.retry_count  = r_retry;

endmodule
